// File: rtl/xoodoo_pkg.sv
// -----------------------------------------------------------------------------
// xoodoo_pkg
// Shared definitions for the iterative Xoodoo permutation engine:
//   - state geometry (3 planes x 4 lanes x 32 bits = 384 bits)
//   - round-constant table RC[0:11], in round order
//   - FSM state encoding for the core
//   - lane_idx(): maps (plane y, lane x) to its 32-bit slot in the flat state
//   - rotl32(): 32-bit rotate toward higher bit index
// No ports (package).
// -----------------------------------------------------------------------------
package xoodoo_pkg;

    localparam int NROUNDS_MAX = 12;
    localparam int LANE_W      = 32;
    localparam int NPLANES     = 3;
    localparam int NLANES      = 4;
    localparam int STATE_W     = LANE_W * NPLANES * NLANES;
    localparam int RC_W        = 12;

    // A build with fewer rounds uses the tail of this list.
    localparam logic [RC_W-1:0] RC [0:NROUNDS_MAX-1] = '{
        12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
        12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Lane A[y][x] sits at bits [32*(x+4y) +: 32] of the flat state.
    function automatic int lane_idx(input int y, input int x);
        return x + NLANES * y;
    endfunction

    function automatic logic [LANE_W-1:0] rotl32(input logic [LANE_W-1:0] v,
                                                 input int                n);
        return (v << n) | (v >> (LANE_W - n));
    endfunction

endpackage

// File: rtl/xoodoo_round.sv
// -----------------------------------------------------------------------------
// xoodoo_round
// One Xoodoo round, purely combinational: theta, rho-west, iota, chi, rho-east.
// Ports:
//   i_state  in  384  state before the round
//   i_rc     in  12   round constant (zero-extended into lane A0[0])
//   o_state  out 384  state after the round
// -----------------------------------------------------------------------------
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [RC_W-1:0]    i_rc,
    output logic [STATE_W-1:0] o_state
);

    always_comb begin
        logic [LANE_W-1:0] a [NPLANES][NLANES];
        logic [LANE_W-1:0] b [NPLANES][NLANES];
        logic [LANE_W-1:0] c [NPLANES][NLANES];
        logic [LANE_W-1:0] p [NLANES];
        logic [LANE_W-1:0] e [NLANES];

        // NOTE: every output of a combinational block gets a value on every
        // path; starting from a full default rules out an inferred latch.
        o_state = '0;

        for (int y = 0; y < NPLANES; y++)
            for (int x = 0; x < NLANES; x++)
                a[y][x] = i_state[LANE_W*lane_idx(y, x) +: LANE_W];

        // theta: column parity of lane x-1, folded back at two rotations
        for (int x = 0; x < NLANES; x++)
            p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < NLANES; x++)
            e[x] = rotl32(p[(x+3)%NLANES], 5) ^ rotl32(p[(x+3)%NLANES], 14);
        for (int y = 0; y < NPLANES; y++)
            for (int x = 0; x < NLANES; x++)
                a[y][x] = a[y][x] ^ e[x];

        // rho-west: plane 1 shifts one lane along x, plane 2 rotates along z
        for (int x = 0; x < NLANES; x++) begin
            b[0][x] = a[0][x];
            b[1][x] = a[1][(x+3)%NLANES];
            b[2][x] = rotl32(a[2][x], 11);
        end

        // iota
        b[0][0] = b[0][0] ^ {{(LANE_W-RC_W){1'b0}}, i_rc};

        // chi: reads only the pre-chi copy b, so plane order does not matter
        for (int y = 0; y < NPLANES; y++)
            for (int x = 0; x < NLANES; x++)
                c[y][x] = b[y][x] ^ (~b[(y+1)%NPLANES][x] & b[(y+2)%NPLANES][x]);

        // rho-east
        for (int x = 0; x < NLANES; x++) begin
            a[0][x] = c[0][x];
            a[1][x] = rotl32(c[1][x], 1);
            a[2][x] = rotl32(c[2][(x+2)%NLANES], 8);
        end

        for (int y = 0; y < NPLANES; y++)
            for (int x = 0; x < NLANES; x++)
                o_state[LANE_W*lane_idx(y, x) +: LANE_W] = a[y][x];
    end

endmodule

// File: rtl/xoodoo_core.sv
// -----------------------------------------------------------------------------
// xoodoo_core
// Iterative Xoodoo[NROUNDS] permutation, one round per clock. Responder side of
// the hash controller's permutation handshake.
// Parameters:
//   NROUNDS     rounds executed (1..12); uses the last NROUNDS round constants
// Ports:
//   clk         in  1    rising-edge clock
//   reset       in  1    asynchronous, active-high; clears all state
//   start       in  1    one-cycle request; ignored while busy
//   state_in    in  384  state to permute, sampled only at the accepting edge
//   state_out   out 384  working register; valid from done until next start
//   done        out 1    one-cycle completion pulse
//   busy        out 1    high while rounds are in progress
// -----------------------------------------------------------------------------
module xoodoo_core
    import xoodoo_pkg::*;
#(
    parameter int NROUNDS = NROUNDS_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               done,
    output logic               busy
);

    localparam int         RC_BASE  = NROUNDS_MAX - NROUNDS;
    localparam logic [3:0] LAST_CNT = 4'(NROUNDS - 1);

    state_e             r_fsm;
    logic [3:0]         r_cnt;
    logic [STATE_W-1:0] r_state;
    logic               r_done;
    logic               r_busy;

    logic [3:0]         w_rc_idx;
    logic [RC_W-1:0]    w_rc;
    logic [STATE_W-1:0] w_next;

    // Counter never exceeds NROUNDS-1, so the index stays inside RC[0:11].
    assign w_rc_idx = 4'(RC_BASE) + r_cnt;
    assign w_rc     = RC[w_rc_idx];

    xoodoo_round u_round (
        .i_state (r_state),
        .i_rc    (w_rc),
        .o_state (w_next)
    );

    // NOTE: the working register is plain flops, not a RAM, so it is reset
    // along with the FSM; a mid-run reset must leave no partial state visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            r_state <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values of the previous cycle, independent of statement order.
            r_done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_state <= state_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_next;
                    if (r_cnt == LAST_CNT) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_fsm  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign state_out = r_state;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule
